// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell per clock, LSB first, with a registered carry.
// Operands and result move over valid/ready handshakes; subtract is a + ~b + 1.
module serial_adder #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_sh_q, sum_sh_d;
    logic            carry_q, carry_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s        = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;

        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        sum       = sum_sh_q;
        cout      = carry_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_sh_d  = a;
                    b_sh_d  = op ? ~b : b;
                    carry_d = op ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                          (b_sh_q[0] & carry_q);
                // Loop form keeps the shift legal when W is 1.
                sum_sh_d[W-1] = s;
                for (int i = 0; i < int'(W) - 1; i++) begin
                    sum_sh_d[i] = sum_sh_q[i+1];
                end
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a W=8 instance for the arithmetic, handshake, backpressure and
// reset-abort cases, plus a W=1 instance for the single-cycle case.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, in_ready, cin = 1'b0, op = 1'b0;
    logic [7:0] a = '0, b = '0, sum;
    logic       out_valid, out_ready = 1'b1, cout, busy;

    logic       in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, op1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       out_valid1, out_ready1 = 1'b1, cout1, busy1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .busy(busy)
    );

    serial_adder #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .cin(cin1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .cout(cout1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation on the W=8 instance and wait for its result.
    task automatic start_and_wait(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                  input logic cv, input logic ov, output int lat);
        @(negedge clk);
        check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a = av; b = bv; cin = cv; op = ov; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hAA; b = 8'h55; cin = ~cv; op = ~ov;  // must not affect the captured operation
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic ov, input logic [7:0] exp_sum,
                          input logic exp_cout);
        int lat;
        out_ready = 1'b1;
        start_and_wait(tag, av, bv, cv, ov, lat);
        check_eq({tag, " latency"}, 32'(lat), 32'd8);
        check_eq({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check_eq({tag, " cout"}, 32'(cout), 32'(exp_cout));
        @(posedge clk); #1;
        check_eq({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        bit stable;
        bit never;

        #2;
        check_eq("reset in_ready", 32'(in_ready), 32'd0);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset sum", 32'(sum), 32'd0);
        check_eq("reset cout", 32'(cout), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op("add basic", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        run_op("carry ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("carry ff+ff+1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        run_op("carry 00+00+1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        run_op("sub 10-01", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
        run_op("sub 01-02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);

        // Backpressure: result held while out_ready is low, new operands refused.
        out_ready = 1'b0;
        start_and_wait("bp", 8'h21, 8'h43, 1'b1, 1'b0, lat);
        out_ready = 1'b0;
        check_eq("bp latency", 32'(lat), 32'd8);
        check_eq("bp sum", 32'(sum), 32'h65);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h0F + 8'(i); b = 8'h01;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || sum !== 8'h65 || cout !== 1'b0 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check_eq("bp held stable", 32'(stable), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp release out_valid", 32'(out_valid), 32'd0);
        run_op("after bp", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);

        // Reset after three RUN edges aborts the operation.
        @(negedge clk);
        a = 8'hFF; b = 8'h01; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort out_valid", 32'(out_valid), 32'd0);
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        never = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) never = 1'b0;
        end
        check_eq("abort no result", 32'(never), 32'd1);
        run_op("after abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // W=1 instance.
        @(negedge clk);
        check_eq("w1 in_ready", 32'(in_ready1), 32'd1);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; op1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w1 latency", 32'(lat), 32'd1);
        check_eq("w1 sum", 32'(sum1), 32'd1);
        check_eq("w1 cout", 32'(cout1), 32'd1);
        @(posedge clk); #1;
        check_eq("w1 in_ready back", 32'(in_ready1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder/subtractor. Accepts two W-bit operands over a valid/ready handshake.
- Evaluates one full-adder cell per clock, LSB first, with a registered carry.
- Returns the W-bit sum and the carry-out over a second valid/ready handshake.
- Sits between the operand source and the result consumer. It is the area-minimal sequential alternative to a W-bit ripple array of full-adder cells.

Parameters:
- W, 8, operand and sum width in bits; legal range W >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in; add mode only
- op  input  1  0 = add (a+b+cin), 1 = subtract (a-b)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  W  result bits
- cout  output  1  final carry; in subtract mode 1 = no borrow (a >= b unsigned)
- busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Internal registers:
  - a_sh, b_sh, sum_sh (W bits each)
  - carry (1 bit)
  - cnt (ceil(log2(W)) bits, minimum 1)
- Reset (async, while rst=1):
  - state=IDLE; all registers 0.
  - in_ready=0, out_valid=0, sum=0, cout=0, busy=0.
- in_ready = (state==IDLE) && !rst. The block accepts no operands in RUN or DONE.
- IDLE, on in_valid && in_ready at an edge (the accept edge):
  - a_sh<=a.
  - b_sh <= op ? ~b : b.
  - carry <= op ? 1 : cin.
  - cnt<=0; state<=RUN.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - sum_sh <= {s, sum_sh[W-1:1]}.
  - a_sh and b_sh shift right by 1.
  - cnt<=cnt+1.
  - When cnt==W-1 at the edge, state<=DONE; that edge still performs the bit operation.
- RUN lasts exactly W edges. out_valid rises exactly W edges after the accept edge.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry.
  - Outputs are registered and held stable while out_ready=0, for an unbounded duration.
  - On out_valid && out_ready at an edge: state<=IDLE. sum and cout keep their last value; they are don't-care once out_valid=0.
- Throughput: one operation per W+2 cycles minimum (accept, W compute edges, result handshake). The next accept can occur on the edge after the result handshake.
- Arithmetic: modulo 2^W sum; carry out of bit W-1 goes to cout. Operands are captured at the accept edge; changes to a, b, cin or op afterwards have no effect.
- in_valid while not in IDLE is ignored; no operand is lost silently, because in_ready=0 in that case.
- out_ready outside DONE is ignored.
- Reset mid-RUN or mid-DONE: the operation is aborted immediately (asynchronous) and no result is produced. The block returns to IDLE when rst deasserts.
- W=1: RUN lasts one edge; cnt never exceeds 0.
- busy = (state != IDLE).

Test Plan:
1. W=8, op=0, a=0x35, b=0x4A, cin=0, out_ready=1. Required:
   - sum=0x7F, cout=0.
   - out_valid high exactly 8 edges after the accept edge, for one cycle.
   - in_ready high again on the following cycle.
2. Carry chain:
   - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
   - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
   - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. Subtract (op=1):
   - a=0x10, b=0x01, cin=1 (must be ignored) -> sum=0x0F, cout=1.
   - a=0x01, b=0x02 -> sum=0xFF, cout=0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required:
   - sum, cout and out_valid stable; in_ready=0; in_valid pulses with new operands are ignored.
   - After out_ready=1, the next operation is accepted on the next edge and gives the correct result.
5. Assert rst for 1 cycle after 3 RUN edges. Required:
   - out_valid=0, busy=0 and in_ready=0 immediately while rst is high; no result is ever produced for the aborted operation.
   - After release, a=0x12, b=0x34 -> sum=0x46, cout=0.
6. Instance with W=1, op=0, a=1, b=1, cin=1. Required: sum=1, cout=1, out_valid 1 edge after the accept edge.
